// File: rtl/mem_port_arbiter.sv
// ---------------------------------------------------------------------------
// mem_port_arbiter
//
// Shares the single memory port between the instruction-fetch requester and
// the data load/store requester. One access at a time moves through
// IDLE -> BUSY -> RESP -> IDLE. The grant is combinational in IDLE. Address,
// write enable and write data are registered toward memory. Read data is
// captured after RD_LAT cycles. A one-cycle done pulse goes back to the owner.
//
// Build option:
//   MISALIGN_CHK_EN  when defined, a granted access with addr[1:0] != 0
//                    skips memory entirely (IDLE -> RESP) and reports err
//                    with its done pulse. When undefined, addresses pass
//                    through unchecked and err is tied low.
//
// Ports:
//   clk, reset        clock, asynchronous active-low reset
//   if_req/if_addr    fetch request (held until if_gnt), fetch address
//   if_gnt/if_done    fetch grant (comb, IDLE only), fetch done pulse
//   d_req/d_we        data request (held until d_gnt), 1 = store
//   d_addr/d_wdata    data address, store data
//   d_gnt/d_done      data grant (comb, IDLE only), data done pulse
//   rdata             registered read data shared by both requesters
//   err               misalignment flag, qualified by if_done/d_done
//   busy              high whenever the sequencer is not idle
//   mem_addr/mem_wr   registered memory address and write enable
//   mem_wdata         registered memory write data
//   mem_rdata         memory read data
// ---------------------------------------------------------------------------
module mem_port_arbiter #(
    parameter int unsigned RD_LAT     = 1,
    parameter int unsigned STARVE_MAX = 4,
    parameter int unsigned CNT_W      = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic        if_gnt,
    output logic        if_done,
    input  logic        d_req,
    input  logic        d_we,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    output logic        d_gnt,
    output logic        d_done,
    output logic [31:0] rdata,
    output logic        err,
    output logic        busy,
    output logic [31:0] mem_addr,
    output logic        mem_wr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata
);

    localparam int unsigned AW = 32;
    localparam int unsigned DW = 32;

    // Latency counter load value: the BUSY phase lasts lat_q + 1 cycles.
    localparam logic [CNT_W-1:0] LAT_LOAD   = CNT_W'(RD_LAT - 1);
    localparam logic [CNT_W-1:0] STARVE_THR = CNT_W'(STARVE_MAX);
    localparam logic [CNT_W-1:0] CNT_MAX    = '1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t            state_q;
    logic              owner_fetch_q;
    logic              is_wr_q;
    logic [CNT_W-1:0]  lat_q;
    logic [CNT_W-1:0]  starve_q;
    logic [CNT_W-1:0]  starve_d;
    logic              if_done_q;
    logic              d_done_q;
    logic [DW-1:0]     rdata_q;
    logic              busy_q;
    logic [AW-1:0]     mem_addr_q;
    logic              mem_wr_q;
    logic [DW-1:0]     mem_wdata_q;
`ifdef MISALIGN_CHK_EN
    logic              err_q;
`endif

    logic [AW-1:0]     gnt_addr;
    logic              gnt_any;
    logic              gnt_wr;
    logic              mis_c;

    // Arbitration: data wins by default, fetch wins once it has starved.
    // Grants are held off while reset is asserted.
    always_comb begin
        if_gnt   = 1'b0;
        d_gnt    = 1'b0;
        starve_d = '0;
        mis_c    = 1'b0;

        if (reset && (state_q == IDLE)) begin
            if (if_req && (!d_req || (starve_q >= STARVE_THR))) begin
                if_gnt = 1'b1;
            end else if (d_req) begin
                d_gnt = 1'b1;
            end
        end

        gnt_any  = if_gnt || d_gnt;
        gnt_wr   = d_gnt && d_we;
        gnt_addr = if_gnt ? if_addr : d_addr;

`ifdef MISALIGN_CHK_EN
        mis_c = (gnt_addr[1:0] != 2'b00);
`endif

        // Saturating count of edges a fetch has waited without a grant.
        if (if_req && !if_gnt) begin
            starve_d = (starve_q == CNT_MAX) ? starve_q : starve_q + CNT_W'(1);
        end
    end

    // Access sequencer and all registered outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q       <= IDLE;
            owner_fetch_q <= 1'b0;
            is_wr_q       <= 1'b0;
            lat_q         <= '0;
            starve_q      <= '0;
            if_done_q     <= 1'b0;
            d_done_q      <= 1'b0;
            rdata_q       <= '0;
            busy_q        <= 1'b0;
            mem_addr_q    <= '0;
            mem_wr_q      <= 1'b0;
            mem_wdata_q   <= '0;
`ifdef MISALIGN_CHK_EN
            err_q         <= 1'b0;
`endif
        end else begin
            starve_q  <= starve_d;
            if_done_q <= 1'b0;
            d_done_q  <= 1'b0;
`ifdef MISALIGN_CHK_EN
            err_q     <= 1'b0;
`endif

            case (state_q)
                IDLE: begin
                    if (gnt_any && mis_c) begin
                        // Misaligned: no memory access, report straight away.
                        owner_fetch_q <= if_gnt;
                        is_wr_q       <= 1'b0;
                        busy_q        <= 1'b1;
                        if_done_q     <= if_gnt;
                        d_done_q      <= d_gnt;
`ifdef MISALIGN_CHK_EN
                        err_q         <= 1'b1;
`endif
                        state_q       <= RESP;
                    end else if (gnt_any) begin
                        owner_fetch_q <= if_gnt;
                        is_wr_q       <= gnt_wr;
                        busy_q        <= 1'b1;
                        mem_addr_q    <= gnt_addr;
                        if (gnt_wr) begin
                            mem_wdata_q <= d_wdata;
                            mem_wr_q    <= 1'b1;
                            lat_q       <= '0;
                        end else begin
                            lat_q       <= LAT_LOAD;
                        end
                        state_q       <= BUSY;
                    end
                end

                BUSY: begin
                    if (lat_q == '0) begin
                        mem_wr_q  <= 1'b0;
                        if (!is_wr_q) begin
                            rdata_q <= mem_rdata;
                        end
                        if_done_q <= owner_fetch_q;
                        d_done_q  <= !owner_fetch_q;
                        state_q   <= RESP;
                    end else begin
                        lat_q     <= lat_q - CNT_W'(1);
                    end
                end

                RESP: begin
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end

                default: begin
                    busy_q   <= 1'b0;
                    mem_wr_q <= 1'b0;
                    state_q  <= IDLE;
                end
            endcase
        end
    end

    assign if_done   = if_done_q;
    assign d_done    = d_done_q;
    assign rdata     = rdata_q;
    assign busy      = busy_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wr    = mem_wr_q;
    assign mem_wdata = mem_wdata_q;
`ifdef MISALIGN_CHK_EN
    assign err       = err_q;
`else
    assign err       = 1'b0;
`endif

endmodule
